// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and sizing helpers for the UART transmit arbiter
package uart_arb_pkg;
   localparam int NREQ_MAX = 8;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_GUARD = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      GRANT = S_GRANT,
      SEND  = S_SEND,
      GUARD = S_GUARD,
      DRAIN = S_DRAIN
   } state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/uart_arb_rrpick.sv
// uart_arb_rrpick: round-robin pick of the first set request at or above ptr, wrapping
module uart_arb_rrpick
   import uart_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [PW-1:0]   index,
   output logic            valid
);
   int w_off;
   int w_best;
   // lowest wrapped distance from ptr wins
   always_comb begin
      index  = '0;
      w_off  = 0;
      w_best = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         w_off = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
         if (req[i] && w_off < w_best) begin
            w_best = w_off;
            index  = PW'(i);
         end
      end
   end
   assign valid  = |req;
   assign onehot = valid ? (NREQ'(1) << index) : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-packet round-robin sharing of one UART transmitter between NREQ virtual UARTs
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   txen,
   input  logic [8*NREQ-1:0] charin,
   output logic [NREQ-1:0]   busy,
   output logic [NREQ-1:0]   grant,
   output logic              uarttxen,
   output logic [7:0]        charout,
   input  logic              uartbusy,
   output logic              timeout
);
   localparam int PW = clog2(NREQ);
   localparam int CW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
   state_t          r_state;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] r_busy;
   logic            r_uarttxen;
   logic            r_timeout;
   logic [7:0]      r_charout;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_owner;
   logic [PW-1:0]   w_next_ptr;
   logic [PW-1:0]   w_pick_idx;
   logic [NREQ-1:0] w_pick_oh;
   logic            w_pick_valid;
   logic            w_expired;
   uart_arb_rrpick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .onehot (w_pick_oh),
      .index  (w_pick_idx),
      .valid  (w_pick_valid)
   );
   assign w_next_ptr = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
   generate
      if (TIMEOUT > 0) begin : g_to
         logic [CW-1:0] r_cnt;
         // idle time of the owner; zero outside GRANT so every GRANT entry starts fresh
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_cnt <= '0;
            else if (r_state != GRANT || txen[r_owner])
               r_cnt <= '0;
            else if (r_cnt != CW'(TIMEOUT))
               r_cnt <= r_cnt + CW'(1);
         end
         assign w_expired = (r_cnt == CW'(TIMEOUT));
      end else begin : g_nto
         assign w_expired = 1'b0;
      end
   endgenerate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_busy     <= '1;
         r_uarttxen <= 1'b0;
         r_charout  <= '0;
         r_timeout  <= 1'b0;
         r_ptr      <= '0;
         r_owner    <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE:
               if (!uartbusy && w_pick_valid) begin
                  r_grant <= w_pick_oh;
                  r_busy  <= ~w_pick_oh;
                  r_owner <= w_pick_idx;
                  r_state <= GRANT;
               end
            GRANT:
               if (txen[r_owner]) begin
                  r_charout  <= charin[8*r_owner +: 8];
                  r_uarttxen <= 1'b1;
                  r_busy     <= '1;
                  r_state    <= SEND;
               end else if (!req[r_owner] || w_expired) begin
                  r_grant   <= '0;
                  r_busy    <= '1;
                  r_ptr     <= w_next_ptr;
                  r_timeout <= req[r_owner];
                  r_state   <= IDLE;
               end
            SEND: begin
               r_uarttxen <= 1'b0;
               r_state    <= GUARD;
            end
            // the core raises uartbusy a cycle late, so its level is not trusted here
            GUARD:
               r_state <= DRAIN;
            DRAIN:
               if (!uartbusy && req[r_owner]) begin
                  r_busy  <= ~r_grant;
                  r_state <= GRANT;
               end else if (!uartbusy) begin
                  r_grant <= '0;
                  r_busy  <= '1;
                  r_ptr   <= w_next_ptr;
                  r_state <= IDLE;
               end
            default:
               r_state <= IDLE;
         endcase
      end
   end
   assign busy     = r_busy;
   assign grant    = r_grant;
   assign uarttxen = r_uarttxen;
   assign charout  = r_charout;
   assign timeout  = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus hand-written corner sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic        clk;
   logic        rst;
   logic [1:0]  req, txen, busy, grant;
   logic [15:0] charin;
   logic        uarttxen, uartbusy, timeout;
   logic [7:0]  charout;
   logic [1:0]  t_req, t_txen, t_busy, t_grant;
   logic [15:0] t_charin;
   logic        t_uarttxen, t_uartbusy, t_timeout;
   logic [7:0]  t_charout;
   logic [2:0]  r3_req, r3_txen, r3_busy, r3_grant;
   logic [23:0] r3_charin;
   logic        r3_uarttxen, r3_uartbusy, r3_timeout;
   logic [7:0]  r3_charout;
   int checks = 0;
   int failures = 0;
   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [1:0]  txen;
      logic [15:0] charin;
      logic        ub;
      logic [1:0]  e_grant;
      logic [1:0]  e_busy;
      logic        e_tx;
      logic [7:0]  e_char;
   } vec_t;
   vec_t vq[$];
   uart_tx_arbiter #(.NREQ(2), .TIMEOUT(4096)) dut (
      .clk(clk), .rst(rst), .req(req), .txen(txen), .charin(charin), .busy(busy),
      .grant(grant), .uarttxen(uarttxen), .charout(charout), .uartbusy(uartbusy), .timeout(timeout)
   );
   uart_tx_arbiter #(.NREQ(2), .TIMEOUT(16)) dut_t (
      .clk(clk), .rst(rst), .req(t_req), .txen(t_txen), .charin(t_charin), .busy(t_busy),
      .grant(t_grant), .uarttxen(t_uarttxen), .charout(t_charout), .uartbusy(t_uartbusy), .timeout(t_timeout)
   );
   uart_tx_arbiter #(.NREQ(3), .TIMEOUT(0)) dut3 (
      .clk(clk), .rst(rst), .req(r3_req), .txen(r3_txen), .charin(r3_charin), .busy(r3_busy),
      .grant(r3_grant), .uarttxen(r3_uarttxen), .charout(r3_charout), .uartbusy(r3_uartbusy), .timeout(r3_timeout)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] tx, input logic [15:0] ch,
                      input logic ub, input logic [1:0] eg, input logic [1:0] eb, input logic et,
                      input logic [7:0] ec);
      vec_t v;
      v.rst = r; v.req = rq; v.txen = tx; v.charin = ch; v.ub = ub;
      v.e_grant = eg; v.e_busy = eb; v.e_tx = et; v.e_char = ec;
      vq.push_back(v);
   endtask
   initial begin
      int n;
      bit seen;
      rst = 1'b1; req = '0; txen = '0; charin = '0; uartbusy = 1'b0;
      t_req = '0; t_txen = '0; t_charin = '0; t_uartbusy = 1'b0;
      r3_req = '0; r3_txen = '0; r3_charin = '0; r3_uartbusy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 2'b11);
      chk("rst_tx", uarttxen, 0);
      chk("rst_char", charout, 0);
      chk("rst_timeout", timeout, 0);
      // single owner: 'P', ',', '\n' with illegal strobes in between
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h00);
      add(0, 2'b01, 2'b01, 16'h0050, 0, 2'b01, 2'b11, 1, 8'h50);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h50);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h50);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h50);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h50);
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h50);
      add(0, 2'b01, 2'b01, 16'h002C, 0, 2'b01, 2'b11, 1, 8'h2C);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h2C);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h2C);
      add(0, 2'b01, 2'b01, 16'h00FF, 1, 2'b01, 2'b11, 0, 8'h2C);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h2C);
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h2C);
      add(0, 2'b01, 2'b10, 16'h4100, 0, 2'b01, 2'b10, 0, 8'h2C);
      add(0, 2'b01, 2'b01, 16'h000A, 0, 2'b01, 2'b11, 1, 8'h0A);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h0A);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h0A);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h0A);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h0A);
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h0A);
      add(0, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 2'b11, 0, 8'h0A);
      // contention from reset
      add(1, 2'b11, 2'b00, 16'h0000, 0, 2'b00, 2'b11, 0, 8'h00);
      add(0, 2'b11, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h00);
      add(0, 2'b10, 2'b00, 16'h0000, 0, 2'b00, 2'b11, 0, 8'h00);
      add(0, 2'b10, 2'b00, 16'h0000, 0, 2'b10, 2'b01, 0, 8'h00);
      add(0, 2'b11, 2'b00, 16'h0000, 0, 2'b10, 2'b01, 0, 8'h00);
      add(0, 2'b11, 2'b10, 16'h4200, 0, 2'b10, 2'b11, 1, 8'h42);
      add(0, 2'b11, 2'b00, 16'h0000, 1, 2'b10, 2'b11, 0, 8'h42);
      add(0, 2'b11, 2'b00, 16'h0000, 1, 2'b10, 2'b11, 0, 8'h42);
      add(0, 2'b11, 2'b00, 16'h0000, 0, 2'b10, 2'b01, 0, 8'h42);
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b00, 2'b11, 0, 8'h42);
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h42);
      // txen with req falling: byte goes out, uartbusy low in GUARD is ignored, then release
      add(0, 2'b00, 2'b01, 16'h0033, 0, 2'b01, 2'b11, 1, 8'h33);
      add(0, 2'b00, 2'b00, 16'h0000, 1, 2'b01, 2'b11, 0, 8'h33);
      add(0, 2'b00, 2'b00, 16'h0000, 0, 2'b01, 2'b11, 0, 8'h33);
      add(0, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 2'b11, 0, 8'h33);
      add(0, 2'b00, 2'b00, 16'h0000, 0, 2'b00, 2'b11, 0, 8'h33);
      add(0, 2'b01, 2'b00, 16'h0000, 1, 2'b00, 2'b11, 0, 8'h33);
      add(0, 2'b01, 2'b00, 16'h0000, 0, 2'b01, 2'b10, 0, 8'h33);
      foreach (vq[i]) begin
         rst = vq[i].rst; req = vq[i].req; txen = vq[i].txen;
         charin = vq[i].charin; uartbusy = vq[i].ub;
         @(negedge clk);
         chk($sformatf("v%0d_grant", i), grant, vq[i].e_grant);
         chk($sformatf("v%0d_busy", i), busy, vq[i].e_busy);
         chk($sformatf("v%0d_tx", i), uarttxen, vq[i].e_tx);
         chk($sformatf("v%0d_char", i), charout, vq[i].e_char);
         chk($sformatf("v%0d_timeout", i), timeout, 0);
      end
      rst = 1'b0; txen = '0;
      // reset while the byte is in SEND
      txen = 2'b01; charin = 16'h0077; req = 2'b01; uartbusy = 1'b0;
      @(negedge clk);
      chk("send_tx", uarttxen, 1);
      txen = '0; uartbusy = 1'b1; rst = 1'b1;
      #1;
      chk("arst_tx", uarttxen, 0);
      chk("arst_grant", grant, 0);
      chk("arst_busy", busy, 2'b11);
      @(negedge clk);
      rst = 1'b0; req = 2'b10;
      @(negedge clk);
      chk("arst_hold", grant, 0);
      uartbusy = 1'b0;
      @(negedge clk);
      chk("arst_regrant", grant, 2'b10);
      // timeout on the TIMEOUT=16 instance
      t_req = 2'b11; n = 0; seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (t_timeout) seen = 1;
         else if (t_grant == 2'b01) n++;
      end
      chk("to_seen", 32'(seen), 1);
      chk("to_len", n, 17);
      chk("to_grant", t_grant, 0);
      chk("to_busy", t_busy, 2'b11);
      @(negedge clk);
      chk("to_pulse", t_timeout, 0);
      chk("to_next", t_grant, 2'b10);
      // NREQ=3 wrap from ptr=2
      r3_req = 3'b010;
      @(negedge clk);
      chk("n3_g1", r3_grant, 3'b010);
      r3_req = 3'b000;
      @(negedge clk);
      chk("n3_rel", r3_grant, 3'b000);
      r3_req = 3'b101;
      @(negedge clk);
      chk("n3_g2", r3_grant, 3'b100);
      chk("n3_b2", r3_busy, 3'b011);
      r3_req = 3'b001;
      @(negedge clk);
      chk("n3_rel2", r3_grant, 3'b000);
      @(negedge clk);
      chk("n3_wrap", r3_grant, 3'b001);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (r3_timeout) seen = 1;
      end
      chk("n3_no_to", 32'(seen), 0);
      chk("n3_hold", r3_grant, 3'b001);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
